mem_port_arbiter: RTL and testbench

Shares one single-ported synchronous word memory between the core's instruction-fetch port and its load/store data port. It arbitrates each cycle with round-robin fairness and supports a data-side lock for atomic read-modify-write sequences. It returns read data one cycle after grant and counts contention cycles for performance debug. It sits between the multicycle core and the unified instruction/data RAM.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous word memory between the instruction-fetch
// and load/store ports, with a data-side lock for atomic sequences and a contention counter.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          locked,
    output logic [CW-1:0] contention_cnt
);

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [CW-1:0] CNT_MAX = '1;

    port_e         last_q,     last_d;
    logic          locked_q,   locked_d;
    logic          i_rvalid_q, i_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic          i_gnt_s;
    logic          d_gnt_s;

    // Grant selection: lock pins the memory to the data port, otherwise the port that did not win last
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!reset) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (locked_q) begin
            d_gnt_s = d_req;
        end else if (i_req && d_req) begin
            i_gnt_s = (last_q == PORT_D);
            d_gnt_s = (last_q == PORT_I);
        end else begin
            i_gnt_s = i_req;
            d_gnt_s = d_req;
        end
    end

    // Next-state for priority, lock, read-owner tags and the saturating contention counter
    always_comb begin
        last_d     = last_q;
        locked_d   = locked_q;
        cnt_d      = cnt_q;
        i_rvalid_d = i_gnt_s;
        d_rvalid_d = d_gnt_s & ~d_we;
        if (i_gnt_s) begin
            last_d = PORT_I;
        end else if (d_gnt_s) begin
            last_d = PORT_D;
        end else begin
            last_d = last_q;
        end
        if (d_gnt_s) begin
            locked_d = d_lock;
        end else begin
            locked_d = locked_q;
        end
        if (i_req && d_req && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset drops any read that is still in flight and releases the lock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= PORT_D;
            locked_q   <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            last_q     <= last_d;
            locked_q   <= locked_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory drive and read steering; the instruction port never writes, so wdata always comes from data
    always_comb begin
        i_gnt          = i_gnt_s;
        d_gnt          = d_gnt_s;
        mem_en         = i_gnt_s | d_gnt_s;
        mem_we         = d_gnt_s & d_we;
        mem_wdata      = d_wdata;
        if (d_gnt_s) begin
            mem_addr = d_addr[AW-1:2];
        end else begin
            mem_addr = i_addr[AW-1:2];
        end
        i_rvalid       = i_rvalid_q;
        d_rvalid       = d_rvalid_q;
        i_rdata        = i_rvalid_q ? mem_rdata : 32'h0000_0000;
        d_rdata        = d_rvalid_q ? mem_rdata : 32'h0000_0000;
        locked         = locked_q;
        contention_cnt = cnt_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences and randomized traffic
// checked against a behavioural model of the arbitration, lock, read-return and counter rules.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_req, d_req, d_we, d_lock;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        locked;
    logic [15:0] contention_cnt;

    logic        x_i_gnt, x_i_rvalid, x_d_gnt, x_d_rvalid, x_mem_en, x_mem_we, x_locked;
    logic [31:0] x_i_rdata, x_d_rdata, x_mem_wdata;
    logic [29:0] x_mem_addr;
    logic [1:0]  cnt2;

    mem_port_arbiter #(.AW(32), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked), .contention_cnt(contention_cnt)
    );

    mem_port_arbiter #(.AW(32), .CW(2)) dut2 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(x_i_gnt), .i_rvalid(x_i_rvalid), .i_rdata(x_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(x_d_gnt), .d_rvalid(x_d_rvalid), .d_rdata(x_d_rdata),
        .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
        .mem_rdata(mem_rdata), .locked(x_locked), .contention_cnt(cnt2)
    );

    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    // Behavioural model state
    int          n_cmp = 0;
    int          n_err = 0;
    bit          m_last;
    bit          m_locked;
    int          m_cnt, m_cnt2;
    bit          p_i, p_d;
    logic [31:0] p_data;
    logic [31:0] sh [0:1023];
    bit          eg_i, eg_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input bit dl, input logic [31:0] da, input logic [31:0] dwd);
        bit winner_d;
        bit np_i, np_d;
        @(negedge clk);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dwd;
        #1;
        if (m_locked) begin
            eg_i = 1'b0; eg_d = dr;
        end else if (ir && dr) begin
            winner_d = (m_last == 1'b0);
            eg_i = !winner_d; eg_d = winner_d;
        end else begin
            eg_i = ir; eg_d = dr;
        end
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("mem_en", mem_en, eg_i | eg_d);
        chk("mem_we", mem_we, eg_d & dw);
        if (eg_d) chk("mem_addr_d", mem_addr, da[31:2]);
        if (eg_i) chk("mem_addr_i", mem_addr, ia[31:2]);
        if (eg_d && dw) chk("mem_wdata", mem_wdata, dwd);
        chk("i_rvalid", i_rvalid, p_i);
        chk("d_rvalid", d_rvalid, p_d);
        chk("i_rdata", i_rdata, p_i ? p_data : 32'h0);
        chk("d_rdata", d_rdata, p_d ? p_data : 32'h0);
        chk("locked", locked, m_locked);
        chk("cnt", contention_cnt, m_cnt);
        chk("cnt2", cnt2, m_cnt2);
        np_i = eg_i;
        np_d = eg_d && !dw;
        if (eg_i) p_data = sh[ia[11:2]];
        else if (np_d) p_data = sh[da[11:2]];
        if (eg_d && dw) sh[da[11:2]] = dwd;
        if (eg_i) m_last = 1'b0;
        if (eg_d) begin m_last = 1'b1; m_locked = dl; end
        if (ir && dr) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        p_i = np_i; p_d = np_d;
    endtask

    task automatic do_reset(input bit ir);
        @(negedge clk);
        reset = 1'b0; i_req = ir; i_addr = 32'h100; d_req = 1'b0;
        #1;
        chk("rst_i_gnt", i_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_i_rvalid", i_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_cnt", contention_cnt, 16'h0);
        chk("rst_cnt2", cnt2, 2'h0);
        m_last = 1'b1; m_locked = 1'b0; m_cnt = 0; m_cnt2 = 0; p_i = 1'b0; p_d = 1'b0;
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0;
    endtask

    typedef struct {
        bit ir, dr, dw, dl;
        bit eig, edg, elk;
        int ecnt;
    } vec_t;
    vec_t tbl [13];

    bit          ri, rd, rdw, rdl;
    logic [31:0] ria, rda, rdwd;

    initial begin
        for (int w = 0; w < 1024; w++) begin
            ram[w] = w * 32'h9E37_79B9 + 32'h0000_1234;
            sh[w]  = ram[w];
        end
        ram[10'h40] = 32'h2402_0005;
        sh[10'h40]  = 32'h2402_0005;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7};

        reset = 1'b0; i_req = 1'b1; i_addr = 32'h100; d_req = 1'b0; d_we = 1'b0;
        d_lock = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        do_reset(1'b1);

        // Instruction fetch from word 0x40
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("fetch_gnt", i_gnt, 1'b1);
        chk("fetch_addr", mem_addr, 30'h40);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("fetch_rvalid", i_rvalid, 1'b1);
        chk("fetch_rdata", i_rdata, 32'h2402_0005);
        chk("fetch_d_rvalid", d_rvalid, 1'b0);

        // Data write then read back
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF);
        chk("wr_mem_we", mem_we, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        chk("rd_d_gnt", d_gnt, 1'b1);
        chk("rd_early_rvalid", d_rvalid, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rd_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("rd_i_rvalid", i_rvalid, 1'b0);

        // Fairness and lock vectors from a fresh reset
        do_reset(1'b0);
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].ir, 32'h100, tbl[k].dr, tbl[k].dw, tbl[k].dl, 32'h200, 32'hDEAD_BEEF);
            chk($sformatf("tbl%0d_i_gnt", k), i_gnt, tbl[k].eig);
            chk($sformatf("tbl%0d_d_gnt", k), d_gnt, tbl[k].edg);
            chk($sformatf("tbl%0d_locked", k), locked, tbl[k].elk);
            chk($sformatf("tbl%0d_cnt", k), contention_cnt, tbl[k].ecnt);
            if (k == 6) chk("cnt2_saturated", cnt2, 2'd3);
        end

        // Locked read granted, then reset in the following cycle drops the read and the lock
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
        chk("midrst_gnt", d_gnt, 1'b1);
        do_reset(1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst_no_rvalid", d_rvalid, 1'b0);

        // Randomized traffic honouring the hold-until-granted handshake
        ri = 1'b0; rd = 1'b0;
        for (int it = 0; it < 800; it++) begin
            if (it % 200 == 199) begin
                do_reset(ri);
                ri = 1'b0; rd = 1'b0;
            end
            if (!ri) begin
                ri  = ($urandom_range(0, 2) != 0);
                ria = $urandom_range(0, 15) << 2;
            end
            if (!rd) begin
                rd   = ($urandom_range(0, 2) != 0);
                rdw  = $urandom_range(0, 1);
                rdl  = ($urandom_range(0, 3) == 0);
                rda  = $urandom_range(0, 15) << 2;
                rdwd = $urandom;
            end
            step(ri, ria, rd, rdw, rdl, rda, rdwd);
            if (eg_i) ri = 1'b0;
            if (eg_d) rd = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
